// File: rtl/cpu_int_pkg.sv
// Shared definitions for the interrupt sequencer: FSM encoding, default vector map
// and the handler-address helper.
package cpu_int_pkg;

  localparam int          N_IRQ_DEF      = 4;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTER = 2'd1,
    ST_SERVE = 2'd2
  } int_state_e;

  // Handler address; the 32-bit result wraps on overflow.
  function automatic logic [31:0] vector_addr(input logic [31:0] base,
                                              input logic [31:0] stride,
                                              input logic [31:0] idx);
    logic [31:0] prod;
    prod = idx * stride;
    return base + prod;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Rising-edge capture of interrupt requests into a pending register, plus a
// fixed-priority encoder (index 0 wins).
module irq_prio_enc #(
  parameter int N_IRQ = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] clr_onehot,
  output logic             any_pending,
  output logic [SEL_W-1:0] sel
);

  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] pending_d;
  logic [N_IRQ-1:0] rise;

  assign rise = irq & ~irq_q;
  // Set wins over clear so an edge arriving with the acknowledge is not lost.
  assign pending_d = (pending_q & ~clr_onehot) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = SEL_W'(i);
    end
  end

  assign any_pending = |pending_q;

endmodule

// File: rtl/pc_int_sequencer.sv
// PC write sequencer: passes the datapath next-PC through, redirects to a handler
// vector at instruction boundaries, and restores from EPC on ERET.
module pc_int_sequencer
  import cpu_int_pkg::*;
#(
  parameter int          N_IRQ      = N_IRQ_DEF,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
  parameter int          SEL_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq,
  input  logic             int_en,
  input  logic             inst_done,
  input  logic             eret,
  input  logic             pc_we_in,
  input  logic [31:0]      pc_seq_next,
  output logic             pc_ce,
  output logic [31:0]      pc_next,
  output logic [31:0]      epc,
  output logic             int_active,
  output logic [SEL_W-1:0] int_cause,
  output logic [N_IRQ-1:0] int_ack,
  output logic             stall,
  output int_state_e       fsm_state
);

  int_state_e       state_q;
  logic [SEL_W-1:0] sel_q;
  logic [31:0]      epc_q;
  logic [SEL_W-1:0] int_cause_q;
  logic             int_active_q;
  logic             any_pending;
  logic [SEL_W-1:0] sel;

  irq_prio_enc #(
    .N_IRQ (N_IRQ),
    .SEL_W (SEL_W)
  ) u_prio (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq         (irq),
    .clr_onehot  (int_ack),
    .any_pending (any_pending),
    .sel         (sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      sel_q        <= '0;
      epc_q        <= '0;
      int_cause_q  <= '0;
      int_active_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (inst_done && int_en && any_pending) begin
            epc_q   <= pc_seq_next;
            sel_q   <= sel;
            state_q <= ST_ENTER;
          end
        end
        ST_ENTER: begin
          int_cause_q  <= sel_q;
          int_active_q <= 1'b1;
          state_q      <= ST_SERVE;
        end
        ST_SERVE: begin
          // No nesting: pending requests wait until we are back in RUN.
          if (inst_done && eret) begin
            int_active_q <= 1'b0;
            state_q      <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Combinational PC control; forced low while reset is asserted.
  always_comb begin
    pc_ce   = pc_we_in;
    pc_next = pc_seq_next;
    stall   = 1'b0;
    int_ack = '0;
    case (state_q)
      ST_ENTER: begin
        pc_ce   = 1'b1;
        pc_next = vector_addr(VEC_BASE, VEC_STRIDE, 32'(sel_q));
        stall   = 1'b1;
        for (int i = 0; i < N_IRQ; i++) int_ack[i] = (sel_q == SEL_W'(i));
      end
      ST_SERVE: begin
        if (inst_done && eret) begin
          pc_ce   = 1'b1;
          pc_next = epc_q;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_ce   = 1'b0;
      pc_next = '0;
      stall   = 1'b0;
      int_ack = '0;
    end
  end

  assign epc        = epc_q;
  assign int_active = int_active_q;
  assign int_cause  = int_cause_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_pc_int_sequencer.sv
// Directed bench for pc_int_sequencer: inputs change on the falling edge, outputs
// are sampled 1 ns later, well away from the rising edge.
module tb_pc_int_sequencer;
  import cpu_int_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq;
  logic        int_en, inst_done, eret, pc_we_in;
  logic [31:0] pc_seq_next;
  logic        pc_ce;
  logic [31:0] pc_next, epc;
  logic        int_active;
  logic [1:0]  int_cause;
  logic [3:0]  int_ack;
  logic        stall;
  int_state_e  fsm_state;

  int nv   = 0;
  int nerr = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  pc_int_sequencer dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .int_en(int_en), .inst_done(inst_done),
    .eret(eret), .pc_we_in(pc_we_in), .pc_seq_next(pc_seq_next), .pc_ce(pc_ce),
    .pc_next(pc_next), .epc(epc), .int_active(int_active), .int_cause(int_cause),
    .int_ack(int_ack), .stall(stall), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    inst_done = 1'b0; eret = 1'b0; pc_we_in = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; irq = '0; int_en = 1'b0; idle(); pc_seq_next = '0;
    #2 rst_n = 1'b0;
    pc_we_in = 1'b1; pc_seq_next = 32'h55;
    repeat (2) @(negedge clk);
    #1;
    if (pc_ce !== 1'b0) begin $display("FAIL rst_pc_ce got=%0b exp=0", pc_ce); nerr++; end nv++;
    if (pc_next !== 32'h0) begin $display("FAIL rst_pc_next got=%h exp=0", pc_next); nerr++; end nv++;
    if (stall !== 1'b0 || int_ack !== 4'h0) begin $display("FAIL rst_stall_ack got=%0b/%b exp=0/0000", stall, int_ack); nerr++; end nv++;
    if (epc !== 32'h0 || int_active !== 1'b0 || int_cause !== 2'd0) begin $display("FAIL rst_regs got=%h/%0b/%0d exp=0/0/0", epc, int_active, int_cause); nerr++; end nv++;
    if (fsm_state !== ST_RUN) begin $display("FAIL rst_state got=%0d exp=%0d", fsm_state, ST_RUN); nerr++; end nv++;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    pc_we_in = 1'b1; pc_seq_next = 32'h40;
    #1;
    if (pc_ce !== 1'b1 || pc_next !== 32'h40) begin $display("FAIL pt_write got=%0b/%h exp=1/00000040", pc_ce, pc_next); nerr++; end nv++;
    if (stall !== 1'b0 || int_ack !== 4'h0) begin $display("FAIL pt_quiet got=%0b/%b exp=0/0000", stall, int_ack); nerr++; end nv++;
    @(negedge clk);
    pc_we_in = 1'b0; pc_seq_next = 32'h44;
    #1;
    if (pc_ce !== 1'b0) begin $display("FAIL pt_nowrite got=%0b exp=0", pc_ce); nerr++; end nv++;
  endtask

  task automatic test_entry();
    step();
    int_en = 1'b1; irq = 4'b0100;
    @(negedge clk);
    inst_done = 1'b1; pc_we_in = 1'b1; pc_seq_next = 32'h1C;
    #1;
    if (pc_ce !== 1'b1 || pc_next !== 32'h1C || stall !== 1'b0) begin $display("FAIL ent_boundary got=%0b/%h/%0b exp=1/0000001c/0", pc_ce, pc_next, stall); nerr++; end nv++;
    step();
    pc_we_in = 1'b0; pc_seq_next = 32'h99;
    #1;
    if (pc_ce !== 1'b1 || pc_next !== 32'h120) begin $display("FAIL ent_vector got=%0b/%h exp=1/00000120", pc_ce, pc_next); nerr++; end nv++;
    if (stall !== 1'b1 || int_ack !== 4'b0100) begin $display("FAIL ent_ack got=%0b/%b exp=1/0100", stall, int_ack); nerr++; end nv++;
    if (epc !== 32'h1C) begin $display("FAIL ent_epc got=%h exp=0000001c", epc); nerr++; end nv++;
    step();
    pc_we_in = 1'b1; pc_seq_next = 32'h124;
    #1;
    if (int_cause !== 2'd2 || int_active !== 1'b1 || fsm_state !== ST_SERVE) begin $display("FAIL ent_serve got=%0d/%0b/%0d exp=2/1/%0d", int_cause, int_active, fsm_state, ST_SERVE); nerr++; end nv++;
    if (pc_ce !== 1'b1 || pc_next !== 32'h124 || stall !== 1'b0 || int_ack !== 4'h0) begin $display("FAIL ent_serve_pt got=%0b/%h/%0b/%b exp=1/00000124/0/0000", pc_ce, pc_next, stall, int_ack); nerr++; end nv++;
    irq = 4'b0000;
  endtask

  task automatic test_eret();
    step();
    inst_done = 1'b1; eret = 1'b1; pc_we_in = 1'b1; pc_seq_next = 32'h124;
    #1;
    if (pc_ce !== 1'b1 || pc_next !== 32'h1C) begin $display("FAIL eret_pc got=%0b/%h exp=1/0000001c", pc_ce, pc_next); nerr++; end nv++;
    step();
    #1;
    if (int_active !== 1'b0 || fsm_state !== ST_RUN) begin $display("FAIL eret_state got=%0b/%0d exp=0/%0d", int_active, fsm_state, ST_RUN); nerr++; end nv++;
    @(negedge clk);
    inst_done = 1'b1; eret = 1'b1; pc_we_in = 1'b1; pc_seq_next = 32'h2C;
    #1;
    if (pc_next !== 32'h2C) begin $display("FAIL eret_in_run got=%h exp=0000002c", pc_next); nerr++; end nv++;
    step();
    #1;
    if (epc !== 32'h1C || fsm_state !== ST_RUN) begin $display("FAIL eret_in_run_epc got=%h/%0d exp=0000001c/%0d", epc, fsm_state, ST_RUN); nerr++; end nv++;
  endtask

  task automatic test_priority();
    exp_q.push_back(32'h110);
    exp_q.push_back(32'h130);
    step();
    irq = 4'b1010;
    @(negedge clk);
    inst_done = 1'b1; pc_we_in = 1'b1; pc_seq_next = 32'h200;
    step();
    #1;
    exp_v = exp_q.pop_front();
    if (pc_next !== exp_v || int_ack !== 4'b0010) begin $display("FAIL prio_first got=%h/%b exp=%h/0010", pc_next, int_ack, exp_v); nerr++; end nv++;
    @(negedge clk);
    inst_done = 1'b1; pc_we_in = 1'b1; pc_seq_next = 32'h114;
    step();
    #1;
    if (fsm_state !== ST_SERVE || int_cause !== 2'd1 || int_ack !== 4'h0) begin $display("FAIL prio_no_nest got=%0d/%0d/%b exp=%0d/1/0000", fsm_state, int_cause, int_ack, ST_SERVE); nerr++; end nv++;
    @(negedge clk);
    inst_done = 1'b1; eret = 1'b1; pc_we_in = 1'b1; pc_seq_next = 32'h118;
    #1;
    if (pc_next !== 32'h200) begin $display("FAIL prio_ret got=%h exp=00000200", pc_next); nerr++; end nv++;
    step();
    #1;
    if (fsm_state !== ST_RUN || stall !== 1'b0) begin $display("FAIL prio_no_chain got=%0d/%0b exp=%0d/0", fsm_state, stall, ST_RUN); nerr++; end nv++;
    @(negedge clk);
    inst_done = 1'b1; pc_we_in = 1'b1; pc_seq_next = 32'h204;
    step();
    #1;
    exp_v = exp_q.pop_front();
    if (pc_next !== exp_v || int_ack !== 4'b1000) begin $display("FAIL prio_second got=%h/%b exp=%h/1000", pc_next, int_ack, exp_v); nerr++; end nv++;
    step();
    #1;
    if (int_cause !== 2'd3 || epc !== 32'h204) begin $display("FAIL prio_second_regs got=%0d/%h exp=3/00000204", int_cause, epc); nerr++; end nv++;
    @(negedge clk);
    inst_done = 1'b1; eret = 1'b1;
    step();
    irq = 4'b0000;
  endtask

  task automatic test_back_to_back();
    step();
    irq = 4'b0100;
    @(negedge clk);
    irq = 4'b0000; inst_done = 1'b1; pc_we_in = 1'b1; pc_seq_next = 32'h500;
    step();
    irq = 4'b0100;
    #1;
    if (int_ack !== 4'b0100) begin $display("FAIL b2b_ack got=%b exp=0100", int_ack); nerr++; end nv++;
    @(negedge clk);
    inst_done = 1'b1; eret = 1'b1; pc_seq_next = 32'h124;
    #1;
    if (pc_next !== 32'h500) begin $display("FAIL b2b_ret got=%h exp=00000500", pc_next); nerr++; end nv++;
    @(negedge clk);
    eret = 1'b0; pc_we_in = 1'b1; pc_seq_next = 32'h504;
    step();
    #1;
    if (int_ack !== 4'b0100 || pc_next !== 32'h120 || epc !== 32'h504) begin $display("FAIL b2b_reentry got=%b/%h/%h exp=0100/00000120/00000504", int_ack, pc_next, epc); nerr++; end nv++;
    @(negedge clk);
    inst_done = 1'b1; eret = 1'b1;
    step();
    irq = 4'b0000;
  endtask

  task automatic test_int_en_gate();
    int_en = 1'b0;
    step();
    irq = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      inst_done = 1'b1; pc_we_in = 1'b1; pc_seq_next = 32'h300 + 32'(i * 4);
      step();
      #1;
      if (fsm_state !== ST_RUN || int_ack !== 4'h0) begin $display("FAIL gate_hold_%0d got=%0d/%b exp=%0d/0000", i, fsm_state, int_ack, ST_RUN); nerr++; end nv++;
    end
    @(negedge clk);
    int_en = 1'b1; inst_done = 1'b1; pc_we_in = 1'b1; pc_seq_next = 32'h400;
    step();
    #1;
    if (pc_next !== 32'h100 || int_ack !== 4'b0001 || epc !== 32'h400) begin $display("FAIL gate_release got=%h/%b/%h exp=00000100/0001/00000400", pc_next, int_ack, epc); nerr++; end nv++;
    step();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    irq = 4'b0011;
    @(negedge clk);
    pc_we_in = 1'b1; pc_seq_next = 32'h77;
    #1;
    if (fsm_state !== ST_SERVE || int_active !== 1'b1) begin $display("FAIL rmid_pre got=%0d/%0b exp=%0d/1", fsm_state, int_active, ST_SERVE); nerr++; end nv++;
    #1 rst_n = 1'b0; irq = 4'b0000;
    #1;
    if (pc_ce !== 1'b0 || pc_next !== 32'h0 || stall !== 1'b0 || int_ack !== 4'h0) begin $display("FAIL rmid_pc got=%0b/%h/%0b/%b exp=0/0/0/0000", pc_ce, pc_next, stall, int_ack); nerr++; end nv++;
    if (epc !== 32'h0 || int_active !== 1'b0 || int_cause !== 2'd0 || fsm_state !== ST_RUN) begin $display("FAIL rmid_regs got=%h/%0b/%0d/%0d exp=0/0/0/%0d", epc, int_active, int_cause, fsm_state, ST_RUN); nerr++; end nv++;
    @(negedge clk);
    rst_n = 1'b1; idle();
    @(negedge clk);
    inst_done = 1'b1; int_en = 1'b1; pc_we_in = 1'b1; pc_seq_next = 32'h600;
    step();
    #1;
    if (fsm_state !== ST_RUN || stall !== 1'b0 || int_ack !== 4'h0) begin $display("FAIL rmid_pending_cleared got=%0d/%0b/%b exp=%0d/0/0000", fsm_state, stall, int_ack, ST_RUN); nerr++; end nv++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_entry();
    test_eret();
    test_priority();
    test_back_to_back();
    test_int_en_gate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end

endmodule
